bin2bcd_display: RTL

Sequential binary-to-BCD converter that feeds the 4-digit seven-segment scanner's 16-bit data input. It takes an unsigned 16-bit binary value, such as a score or counter from the ALU/register path, and converts it with iterative shift-add-3 (double dabble). It holds the result as four packed BCD nibbles so the display shows decimal instead of hex. Values above 9999 saturate and raise a flag.

---
 rtl/bin2bcd_display.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bin2bcd_display.sv
// bin2bcd_display: sequential 16-bit binary to 4-digit packed BCD converter.
// Uses shift-add-3 (double dabble), one bit per clock, and saturates values
// above 9999 to 9999 with ovf set. Outputs only change on completion, so the
// downstream seven-segment scanner never sees partial results.
module bin2bcd_display #(
  parameter bit AUTO = 1'b1  // 1: reconvert whenever bin_in differs from last converted value
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bin_in,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd_out,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic [15:0] last_val_q, last_val_d;
  logic [19:0] scratch_q, scratch_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;

  logic [15:0] scratch_adj;
  logic        start;

  // Add-3 correction on the four low BCD nibbles. The fifth (overflow) nibble
  // can hold at most 3 before the final shift of a 16-bit input, so it never
  // needs correcting and is passed straight through.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign scratch_adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5)
                                      ? scratch_q[gi*4 +: 4] + 4'd3
                                      : scratch_q[gi*4 +: 4];
    end
  endgenerate

  // A conversion starts on an explicit request, a remembered request, or
  // (in auto mode) when the input no longer matches the last converted value.
  assign start = load | pending_q | (AUTO && (bin_in != last_val_q));

  // Next-state and datapath control; everything holds unless a state acts on it.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    last_val_d = last_val_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d    = bin_in;
          last_val_d = bin_in;
          scratch_d  = 20'd0;
          cnt_d      = 5'd0;
          pending_d  = 1'b0;
          busy_d     = 1'b1;
          state_d    = CONV;
        end
      end
      CONV: begin
        scratch_d = {scratch_q[18:16], scratch_adj, shreg_q[15]};
        shreg_d   = {shreg_q[14:0], 1'b0};
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d = FINISH;
        end
        if (load) begin
          pending_d = 1'b1;
        end
      end
      FINISH: begin
        if (scratch_q[19:16] != 4'd0) begin
          bcd_d = 16'h9999;
          ovf_d = 1'b1;
        end else begin
          bcd_d = scratch_q[15:0];
          ovf_d = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (load) begin
          pending_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= 16'd0;
      last_val_q <= 16'd0;
      scratch_q  <= 20'd0;
      cnt_q      <= 5'd0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= 16'h0000;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      last_val_q <= last_val_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

endmodule
